riscv_fetch_unit: RTL

- Instruction-fetch front end that sits directly upstream of the RISC-V core's decode stage.
- Generates sequential fetch addresses to instruction memory and buffers returned words in a small FIFO.
- Presents {instr, pc} to decode with a valid/ready handshake.
- Handles branch/jump redirects: flushes buffered words and discards responses still in flight.

---
 rtl/riscv_pkg.sv | 7 +
 rtl/riscv_fetch_fifo.sv | 45 ++++
 rtl/riscv_fetch_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V instruction-fetch front end and its benches.
package riscv_pkg;
    localparam int unsigned XLEN             = 32;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
endpackage

// File: rtl/riscv_fetch_fifo.sv
// Instruction word FIFO between the memory response path and decode.
// Flush empties it and overrides any push or pop in the same cycle.
module riscv_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head_data
);
    import riscv_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PW'(1);
            if (i_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage needs no reset; count gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (reset && !i_flush && i_push) r_mem[r_wptr] <= i_push_data;
    end

    assign o_count     = r_count;
    assign o_head_data = r_mem[r_rptr];
endmodule

// File: rtl/riscv_fetch_unit.sv
// Fetch front end: sequential PC generation, credit-limited requests,
// in-order response buffering and redirect flush with stale-response drop.
module riscv_fetch_unit #(
    parameter int unsigned XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT),
    parameter int unsigned DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
);
    import riscv_pkg::*;

    localparam int unsigned     CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C    = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] INSTR_STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_head_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_credit_used;
    logic [XLEN-1:0] w_target_pc;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;
    logic            w_unused_pc_lsb;

    assign w_target_pc     = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    // Credits cover both buffered words and words still in flight, so a
    // response can never arrive to a full FIFO.
    assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req      = reset && !redirect_valid && (w_credit_used < DEPTH_C);
    assign imem_addr     = r_fetch_pc;

    assign w_rsp    = imem_rvalid && (r_outstanding != '0);
    assign w_push   = w_rsp && (r_drop_cnt == '0) && !redirect_valid;
    assign if_valid = reset && (w_count != '0);
    assign w_pop    = if_valid && id_ready && !redirect_valid;
    assign if_pc    = r_head_pc;

    riscv_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (imem_rdata),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_count),
        .o_head_data (if_instr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_head_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(imem_req) - CW'(w_rsp);
            if (redirect_valid) begin
                r_fetch_pc <= w_target_pc;
                r_head_pc  <= w_target_pc;
                // Everything still in flight after this edge belongs to the old path.
                r_drop_cnt <= r_outstanding - CW'(w_rsp);
            end else begin
                if (imem_req) r_fetch_pc <= r_fetch_pc + INSTR_STEP;
                if (w_pop)    r_head_pc  <= r_head_pc + INSTR_STEP;
                if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && (r_outstanding == '0)));
endmodule
